// File: rtl/wwm_pkg.sv
// Shared constants and types for the projectile, state machine and display blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the one-hot state encoding, the target box and play-field limits,
// the fixed-point fraction width and a saturating position-step helper.
package wwm_pkg;

    localparam int FRAC = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_ARMED  = 4'b0010,
        ST_FLY    = 4'b0100,
        ST_LANDED = 4'b1000
    } state_t;

    // Target box (inclusive)
    localparam logic [9:0] TGT_X_MIN = 10'd650;
    localparam logic [9:0] TGT_X_MAX = 10'd675;
    localparam logic [9:0] TGT_Y_MIN = 10'd470;
    localparam logic [9:0] TGT_Y_MAX = 10'd475;

    // Play-field limits: at or beyond any of these the shot is out
    localparam logic [9:0] OOB_X_HI = 10'd775;
    localparam logic [9:0] OOB_X_LO = 10'd160;
    localparam logic [9:0] OOB_Y_HI = 10'd475;
    localparam logic [9:0] OOB_Y_LO = 10'd50;

    // Adds a signed velocity to an unsigned 10.4 position. Result bit 14 flags
    // that the sum left the 0..1023 px range and was clamped.
    function automatic logic [14:0] step_pos(input logic [13:0] pos,
                                             input logic signed [9:0] vel);
        logic signed [15:0] sum;
        sum = $signed({2'b00, pos}) + 16'(vel);
        if (sum[15])
            step_pos = {1'b1, 14'd0};
        else if (sum[14])
            step_pos = {1'b1, 14'h3FFF};
        else
            step_pos = {1'b0, sum[13:0]};
    endfunction

endpackage

// File: rtl/wwm_proj_bounds.sv
// Classifies an integer pixel position as hit / out-of-bounds / neither.
// Latency: combinational.
// Backpressure: none.
//
// Ports: x, y (integer pixel) in; hit, out_of_bounds out.
// hit wins over out_of_bounds, so the two are never both high (the box's
// bottom edge Y=475 coincides with the lower field limit).
module wwm_proj_bounds
    import wwm_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       hit,
    output logic       out_of_bounds
);

    logic in_box;
    logic outside;

    assign in_box  = (x >= TGT_X_MIN) && (x <= TGT_X_MAX) &&
                     (y >= TGT_Y_MIN) && (y <= TGT_Y_MAX);
    assign outside = (x >= OOB_X_HI) || (x <= OOB_X_LO) ||
                     (y >= OOB_Y_HI) || (y <= OOB_Y_LO);

    assign hit           = in_box;
    assign out_of_bounds = outside && !in_box;

endmodule

// File: rtl/wwm_projectile.sv
// Projectile kinematics: latch launch velocity, step position once per frame under gravity.
// Latency: position/flags update on the clock edge of the qualifying frame_tick.
// Backpressure: none; launch pulses outside IDLE are dropped.
//
// Ports: clk, Reset_n (async active-low); frame_tick, launch, animate,
// vx_init/vy_init (signed 1/16 px/frame) in; projectileCenterX/Y (integer px),
// in_flight, hit, out_of_bounds (registered), flight_frames (saturating) out.
// Optional: define WWM_PROJ_DRAG_EN to bleed |vx| by 1 every 8th flight frame.
module wwm_projectile
    import wwm_pkg::*;
#(
    parameter logic        [9:0] PROJ_X0 = 10'd200,
    parameter logic        [9:0] PROJ_Y0 = 10'd300,
    parameter logic signed [9:0] GRAVITY = 10'sd4
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic              launch,
    input  logic              animate,
    input  logic signed [9:0] vx_init,
    input  logic signed [9:0] vy_init,
    output logic        [9:0] projectileCenterX,
    output logic        [9:0] projectileCenterY,
    output logic              in_flight,
    output logic              hit,
    output logic              out_of_bounds,
    output logic        [7:0] flight_frames
);

    localparam logic [13:0] PARK_X = 14'(PROJ_X0) << FRAC;
    localparam logic [13:0] PARK_Y = 14'(PROJ_Y0) << FRAC;

    state_t             state;
    logic        [13:0] pos_x, pos_y;
    logic signed [9:0]  vx, vy;

    logic        [14:0] step_x, step_y;
    logic               bnd_hit, bnd_oob, oob_next;
    logic signed [10:0] vy_sum;
    logic signed [9:0]  vy_next, vx_next;
    logic        [7:0]  ff_next;
    logic               do_step, do_repark;

    // Next-frame kinematics, evaluated every cycle, committed only on do_step
    always_comb begin
        step_x  = step_pos(pos_x, vx);
        step_y  = step_pos(pos_y, vy);
        ff_next = (flight_frames == 8'd255) ? 8'd255 : flight_frames + 8'd1;

        // vy += GRAVITY, clamped instead of wrapping (overflow when the two
        // top bits of the 11-bit sum disagree)
        vy_sum = 11'(vy) + 11'(GRAVITY);
        if (vy_sum[10] != vy_sum[9])
            vy_next = vy_sum[10] ? -10'sd512 : 10'sd511;
        else
            vy_next = vy_sum[9:0];

        vx_next = vx;
`ifdef WWM_PROJ_DRAG_EN
        if (ff_next[2:0] == 3'd7) begin
            if (vx > 10'sd0)
                vx_next = vx - 10'sd1;
            else if (vx < 10'sd0)
                vx_next = vx + 10'sd1;
        end
`endif
    end

    wwm_proj_bounds u_bounds (
        .x             (step_x[13:FRAC]),
        .y             (step_y[13:FRAC]),
        .hit           (bnd_hit),
        .out_of_bounds (bnd_oob)
    );

    // A clamped step always ends the shot, but never overrides a hit
    assign oob_next = !bnd_hit && (bnd_oob || step_x[14] || step_y[14]);

    always_comb begin
        do_step   = 1'b0;
        do_repark = 1'b0;
        case (state)
            ST_IDLE:   ;
            ST_ARMED:  do_step = frame_tick && animate;
            ST_FLY: begin
                do_repark = !animate;
                do_step   = animate && frame_tick;
            end
            ST_LANDED: do_repark = !animate;
            default:   do_repark = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_IDLE;
            pos_x         <= PARK_X;
            pos_y         <= PARK_Y;
            vx            <= '0;
            vy            <= '0;
            hit           <= 1'b0;
            out_of_bounds <= 1'b0;
            flight_frames <= '0;
        end else if (do_repark) begin
            state         <= ST_IDLE;
            pos_x         <= PARK_X;
            pos_y         <= PARK_Y;
            vx            <= '0;
            vy            <= '0;
            hit           <= 1'b0;
            out_of_bounds <= 1'b0;
            flight_frames <= '0;
        end else if (do_step) begin
            pos_x         <= step_x[13:0];
            pos_y         <= step_y[13:0];
            vx            <= vx_next;
            vy            <= vy_next;
            flight_frames <= ff_next;
            hit           <= bnd_hit;
            out_of_bounds <= oob_next;
            state         <= (bnd_hit || oob_next) ? ST_LANDED : ST_FLY;
        end else if (state == ST_IDLE && launch) begin
            // frame_tick in this same cycle is deliberately ignored
            vx    <= vx_init;
            vy    <= vy_init;
            state <= ST_ARMED;
        end
    end

    assign projectileCenterX = pos_x[13:FRAC];
    assign projectileCenterY = pos_y[13:FRAC];
    assign in_flight         = (state == ST_FLY);

endmodule

// File: tb/tb_wwm_projectile.sv
module tb_wwm_projectile;

    logic              clk = 1'b0;
    logic              Reset_n;
    logic              frame_tick;
    logic              launch;
    logic              animate;
    logic signed [9:0] vx_init;
    logic signed [9:0] vy_init;
    logic        [9:0] projectileCenterX;
    logic        [9:0] projectileCenterY;
    logic              in_flight;
    logic              hit;
    logic              out_of_bounds;
    logic        [7:0] flight_frames;

    int total  = 0;
    int passes = 0;

    wwm_projectile dut (
        .clk               (clk),
        .Reset_n           (Reset_n),
        .frame_tick        (frame_tick),
        .launch            (launch),
        .animate           (animate),
        .vx_init           (vx_init),
        .vy_init           (vy_init),
        .projectileCenterX (projectileCenterX),
        .projectileCenterY (projectileCenterY),
        .in_flight         (in_flight),
        .hit               (hit),
        .out_of_bounds     (out_of_bounds),
        .flight_frames     (flight_frames)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic fire(input int vx, input int vy);
        @(negedge clk);
        launch  = 1'b1;
        vx_init = 10'(vx);
        vy_init = 10'(vy);
        @(negedge clk) launch = 1'b0;
    endtask

    task automatic abort_shot();
        @(negedge clk) animate = 1'b0;
        @(negedge clk) animate = 1'b1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        launch     = 1'b0;
        animate    = 1'b0;
        vx_init    = '0;
        vy_init    = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_x",   projectileCenterX, 200);
        check("rst_y",   projectileCenterY, 300);
        check("rst_fly", in_flight, 0);
        check("rst_hit", hit, 0);
        check("rst_oob", out_of_bounds, 0);
        check("rst_ff",  flight_frames, 0);
        Reset_n = 1'b1;
        animate = 1'b1;

        // launch and frame_tick together in IDLE: launch taken, no motion
        @(negedge clk);
        launch = 1'b1; frame_tick = 1'b1; vx_init = 10'sd64; vy_init = 10'sd0;
        @(negedge clk);
        launch = 1'b0; frame_tick = 1'b0;
        check("armed_x",   projectileCenterX, 200);
        check("armed_fly", in_flight, 0);
        check("armed_ff",  flight_frames, 0);

        // First tick: 64/16 = 4 px, vy still 0 for this step
        tick(1);
        check("t1_x",   projectileCenterX, 204);
        check("t1_y",   projectileCenterY, 300);
        check("t1_fly", in_flight, 1);
        check("t1_ff",  flight_frames, 1);

        // Five ticks: vy used 0+4+8+12+16 = 40/16 -> 302
        tick(4);
        check("t5_x",  projectileCenterX, 220);
        check("t5_y",  projectileCenterY, 302);
        check("t5_ff", flight_frames, 5);

        // Second launch mid-flight is ignored
        fire(-100, -100);
        tick(1);
        check("relaunch_x",  projectileCenterX, 224);
        check("relaunch_y",  projectileCenterY, 303);
        check("relaunch_ff", flight_frames, 6);

        // Drop animate: re-park on the next edge
        @(negedge clk) animate = 1'b0;
        @(negedge clk);
        check("abort_x",   projectileCenterX, 200);
        check("abort_y",   projectileCenterY, 300);
        check("abort_fly", in_flight, 0);
        check("abort_ff",  flight_frames, 0);
        check("abort_oob", out_of_bounds, 0);
        animate = 1'b1;

        // Leftward shot: X=160 on tick 10 exactly
        fire(-64, 0);
        tick(9);
        check("left9_x",   projectileCenterX, 164);
        check("left9_oob", out_of_bounds, 0);
        tick(1);
        check("left10_x",   projectileCenterX, 160);
        check("left10_y",   projectileCenterY, 311);
        check("left10_oob", out_of_bounds, 1);
        check("left10_hit", hit, 0);
        check("left10_fly", in_flight, 0);
        check("left10_ff",  flight_frames, 10);
        tick(3);
        check("landed_x",   projectileCenterX, 160);
        check("landed_y",   projectileCenterY, 311);
        check("landed_ff",  flight_frames, 10);
        check("landed_oob", out_of_bounds, 1);
        abort_shot();
        check("repark_oob", out_of_bounds, 0);
        check("repark_x",   projectileCenterX, 200);

        // Hit on tick 52 at (655,475): Y=475 is also the field limit, hit wins
        fire(140, -48);
        tick(51);
        check("pre_hit_x",   projectileCenterX, 646);
        check("pre_hit_y",   projectileCenterY, 465);
        check("pre_hit_hit", hit, 0);
        check("pre_hit_oob", out_of_bounds, 0);
        tick(1);
        check("hit_x",   projectileCenterX, 655);
        check("hit_y",   projectileCenterY, 475);
        check("hit_hit", hit, 1);
        check("hit_oob", out_of_bounds, 0);
        check("hit_ff",  flight_frames, 52);
        check("hit_fly", in_flight, 0);
        abort_shot();
        check("hit_clr", hit, 0);

        // Asynchronous reset between edges
        fire(64, 0);
        tick(2);
        check("pre_rst_x", projectileCenterX, 208);
        @(posedge clk);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_x",   projectileCenterX, 200);
        check("arst_y",   projectileCenterY, 300);
        check("arst_ff",  flight_frames, 0);
        check("arst_fly", in_flight, 0);
        @(negedge clk) Reset_n = 1'b1;
        tick(3);
        check("post_rst_x",   projectileCenterX, 200);
        check("post_rst_fly", in_flight, 0);

        // Slow horizontal shot: drag bleeds vx after frames 7, 15, 23
        fire(3, 0);
        tick(24);
`ifdef WWM_PROJ_DRAG_EN
        check("drag24_x", projectileCenterX, 202);
`else
        check("drag24_x", projectileCenterX, 204);
`endif
        tick(8);
`ifdef WWM_PROJ_DRAG_EN
        check("drag32_x", projectileCenterX, 202);
`else
        check("drag32_x", projectileCenterX, 206);
`endif
        check("drag32_y",  projectileCenterY, 424);
        check("drag32_ff", flight_frames, 32);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
